// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider (DIV/DIVU), quotient to lo, remainder to hi
// Optional feature: DIV_ZERO_SHORTCUT_EN skips the iteration phase when the divisor is zero.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             annul,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state, next_state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q, rem, bmag, a_orig;
  logic             a_sign, b_sign, sdiv, b_zero;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   rem_sh, rem_sub;
  logic             zero_b_in, last_iter, neg_q, neg_r, accept;

  always_comb begin
    a_abs     = (signed_div && a[WIDTH-1]) ? -a : a;
    b_abs     = (signed_div && b[WIDTH-1]) ? -b : b;
    zero_b_in = (b == '0);
    accept    = start && !annul;
    rem_sh    = {rem, q[WIDTH-1]};
    // bit WIDTH of the difference is the borrow: set means rem_sh < |b|
    rem_sub   = rem_sh - {1'b0, bmag};
    last_iter = (cnt == CW'(WIDTH - 1));
    neg_q     = sdiv && (a_sign ^ b_sign);
    neg_r     = sdiv && a_sign;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef DIV_ZERO_SHORTCUT_EN
          next_state = zero_b_in ? FIX : RUN;
`else
          next_state = RUN;
`endif
        end
      end
      RUN:     if (last_iter) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (annul) next_state = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      q      <= '0;
      rem    <= '0;
      bmag   <= '0;
      a_orig <= '0;
      a_sign <= 1'b0;
      b_sign <= 1'b0;
      sdiv   <= 1'b0;
      b_zero <= 1'b0;
    end else begin
      busy <= (next_state != IDLE);
      done <= (state == FIX) && !annul;
      case (state)
        IDLE: begin
          if (accept) begin
            q      <= a_abs;
            rem    <= '0;
            bmag   <= b_abs;
            a_orig <= a;
            a_sign <= a[WIDTH-1];
            b_sign <= b[WIDTH-1];
            sdiv   <= signed_div;
            b_zero <= zero_b_in;
            cnt    <= '0;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (!rem_sub[WIDTH]) begin
            rem <= rem_sub[WIDTH-1:0];
            q   <= {q[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_sh[WIDTH-1:0];
            q   <= {q[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          if (!annul) begin
            if (b_zero) begin
              hi <= a_orig;
              lo <= '1;
            end else begin
              lo <= neg_q ? -q : q;
              hi <= neg_r ? -rem : rem;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, signed_div, annul;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          busy_cycles;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_hi, last_lo;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .a(a), .b(b), .annul(annul), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic sd, input logic [31:0] x, input logic [31:0] y);
    exp_t r;
    if (y == 32'd0) begin
      r.hi = x;
      r.lo = 32'hFFFF_FFFF;
    end else if (sd && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      r.hi = 32'd0;
      r.lo = 32'h8000_0000;
    end else if (sd) begin
      r.lo = 32'($signed(x) / $signed(y));
      r.hi = 32'($signed(x) % $signed(y));
    end else begin
      r.lo = x / y;
      r.hi = x % y;
    end
`ifdef DIV_ZERO_SHORTCUT_EN
    r.lat         = (y == 32'd0) ? 1 : 33;
    r.busy_cycles = (y == 32'd0) ? 1 : 33;
`else
    r.lat         = 33;
    r.busy_cycles = 33;
`endif
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the edge that sampled start.
  task automatic start_op(input logic sd, input logic [31:0] x, input logic [31:0] y);
    sb.push_back(model(sd, x, y));
    signed_div = sd; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(input string name);
    int   n, bc;
    bit   got;
    exp_t e;
    got = 0; bc = busy ? 1 : 0; n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin n = i; got = 1; break; end
      if (busy) bc++;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: no done within 100 cycles", name);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    checks++;
    if (lo !== e.lo) begin errors++; $display("FAIL %s lo: got %h want %h", name, lo, e.lo); end
    checks++;
    if (hi !== e.hi) begin errors++; $display("FAIL %s hi: got %h want %h", name, hi, e.hi); end
    checks++;
    if (n != e.lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, n, e.lat); end
    checks++;
    if (bc != e.busy_cycles) begin errors++; $display("FAIL %s busy_cycles: got %0d want %0d", name, bc, e.busy_cycles); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_in_done: got %b want 0", name, busy); end
    last_hi = e.hi; last_lo = e.lo;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset hi: got %h want 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset lo: got %h want 0", lo); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_divu;
    start_op(1'b0, 32'd100, 32'd7);
    wait_done("divu_100_7");
    checks++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      errors++; $display("FAIL divu_const: got lo=%0d hi=%0d want lo=14 hi=2", lo, hi);
    end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b want 0", done); end
  endtask

  task automatic test_div_signed;
    start_op(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_m7_2");
    checks++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL div_signed_const: got lo=%h hi=%h want lo=fffffffd hi=ffffffff", lo, hi);
    end
    for (int i = 0; i < 6; i++) begin
      start_op(1'($urandom_range(0, 1)), $urandom, (i == 0) ? 32'hFFFF_FFF3 : 32'($urandom_range(1, 70000)));
      wait_done($sformatf("random_%0d", i));
    end
  endtask

  task automatic test_back_to_back;
    start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_overflow");
    checks++;
    if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
      errors++; $display("FAIL overflow_const: got lo=%h hi=%h want lo=80000000 hi=0", lo, hi);
    end
    start_op(1'b0, 32'd9, 32'd3);
    wait_done("b2b_divu_9_3");
  endtask

  task automatic test_start_ignored;
    sb.push_back(model(1'b0, 32'd50, 32'd5));
    signed_div = 1'b0; a = 32'd50; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    signed_div = 1'b1; a = 32'd77; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // four RUN cycles consumed before the ignored start plus the one just above
    for (int i = 0; i < 100; i++) begin
      if (done) break;
      @(posedge clk); #1;
    end
    checks++;
    if (done !== 1'b1 || lo !== 32'd10 || hi !== 32'd0) begin
      errors++; $display("FAIL start_while_busy: got done=%b lo=%0d hi=%0d want done=1 lo=10 hi=0", done, lo, hi);
    end
    void'(sb.pop_front());
    last_hi = 32'd0; last_lo = 32'd10;
    @(posedge clk); #1;
  endtask

  task automatic test_annul;
    int seen;
    signed_div = 1'b0; a = 32'd50; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL annul_busy: got %b want 0", busy); end
    annul = 1'b1; start = 1'b1; a = 32'd1; b = 32'd1;
    @(posedge clk); #1;
    annul = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL annul_start_busy: got %b want 0", busy); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL annul_no_done: got %0d pulses want 0", seen); end
    checks++;
    if (hi !== last_hi || lo !== last_lo) begin
      errors++; $display("FAIL annul_hold: got hi=%h lo=%h want hi=%h lo=%h", hi, lo, last_hi, last_lo);
    end
  endtask

  task automatic test_div_zero;
    start_op(1'b0, 32'h1234, 32'd0);
    wait_done("divu_by_zero");
    checks++;
    if (hi !== 32'h1234 || lo !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL div_zero_const: got hi=%h lo=%h want hi=1234 lo=ffffffff", hi, lo);
    end
    start_op(1'b1, 32'hFFFF_FF00, 32'd0);
    wait_done("div_by_zero_signed");
  endtask

  task automatic test_reset_mid;
    signed_div = 1'b0; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b want 0", done); end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL midreset_hilo: got hi=%h lo=%h want 0 0", hi, lo);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_no_done: got %b want 0", done); end
    end
  endtask

  initial begin
    test_reset;
    test_divu;
    test_div_signed;
    test_back_to_back;
    test_start_ignored;
    test_annul;
    test_div_zero;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
